// File: rtl/input_feature_packer.sv
// input_feature_packer: quantizes signed features to 2-bit codes and packs
// NUM_FEATURES codes into one vector behind a registered valid/ready port.
// One assembly buffer plus the output register form a two-deep pipeline, so
// the next vector fills while the previous one waits for the consumer.
module input_feature_packer #(
  parameter int                     NUM_FEATURES = 16,
  parameter int                     IN_W         = 16,
  parameter logic signed [IN_W-1:0] TH0          = IN_W'(-256),
  parameter logic signed [IN_W-1:0] TH1          = IN_W'(0),
  parameter logic signed [IN_W-1:0] TH2          = IN_W'(256)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_W-1:0]           s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUM_FEATURES-1:0] m_data,
  output logic                      err_len
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int DW    = 2 * NUM_FEATURES;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);

  // FILL: accepting features into the assembly buffer.
  // FULL: assembly buffer holds a complete vector waiting for the output.
  typedef enum logic {FILL, FULL} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [DW-1:0]    asm_reg, asm_next;
  logic [DW-1:0]    asm_ins;
  logic [DW-1:0]    m_data_reg, m_data_next;
  logic             m_valid_reg, m_valid_next;
  logic             err_reg, err_next;
  logic             s_ready_reg;
  logic [1:0]       code;
  logic             accept;
  logic             last_pos;
  logic             drain;
  logic             out_free;

  // Quantize the incoming feature against the three signed thresholds.
  always_comb begin
    code = 2'd3;
    if ($signed(s_data) < TH0)      code = 2'd0;
    else if ($signed(s_data) < TH1) code = 2'd1;
    else if ($signed(s_data) < TH2) code = 2'd2;
  end

  // Assembly buffer with the current code dropped into slot idx.
  generate
    for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_slot
      assign asm_ins[2*gi+1:2*gi] = (idx_reg == IDX_W'(gi)) ? code : asm_reg[2*gi+1:2*gi];
    end
  endgenerate

  assign accept   = s_valid && s_ready_reg;
  assign last_pos = (idx_reg == IDX_LAST);
  assign drain    = m_valid_reg && m_ready;
  assign out_free = !m_valid_reg || m_ready;

  // Next-state, assembly, commit and framing-error decisions.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    asm_next     = asm_reg;
    m_data_next  = m_data_reg;
    m_valid_next = m_valid_reg;
    err_next     = 1'b0;

    if (drain) m_valid_next = 1'b0;

    case (state_reg)
      FILL: begin
        if (accept) begin
          if (last_pos) begin
            // Vector complete; a missing s_last is flagged but the vector still goes out.
            idx_next = '0;
            err_next = !s_last;
            if (out_free) begin
              m_data_next  = asm_ins;
              m_valid_next = 1'b1;
              asm_next     = '0;
            end else begin
              asm_next   = asm_ins;
              state_next = FULL;
            end
          end else if (s_last) begin
            // Short frame: drop the partial vector.
            err_next = 1'b1;
            asm_next = '0;
            idx_next = '0;
          end else begin
            asm_next = asm_ins;
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      FULL: begin
        if (drain) begin
          m_data_next  = asm_reg;
          m_valid_next = 1'b1;
          asm_next     = '0;
          state_next   = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State and datapath registers; s_ready is registered so it stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FILL;
      idx_reg     <= '0;
      asm_reg     <= '0;
      m_data_reg  <= '0;
      m_valid_reg <= 1'b0;
      err_reg     <= 1'b0;
      s_ready_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      asm_reg     <= asm_next;
      m_data_reg  <= m_data_next;
      m_valid_reg <= m_valid_next;
      err_reg     <= err_next;
      s_ready_reg <= (state_next == FILL);
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign err_len = err_reg;

endmodule

// File: tb/tb_input_feature_packer.sv
// Testbench for input_feature_packer: directed scenarios plus random traffic,
// checked every cycle against a queue-based transaction model.
module tb_input_feature_packer;

  localparam int N    = 4;
  localparam int IN_W = 16;
  localparam int DW   = 2 * N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [IN_W-1:0] s_data = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_data;
  logic            err_len;

  input_feature_packer #(
    .NUM_FEATURES(N),
    .IN_W        (IN_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int vcount = 0;

  // Reference model: codes of the frame being assembled, and completed
  // vectors not yet taken by the consumer (front is what m_data shows).
  bit [1:0]      cur[$];
  logic [DW-1:0] outq[$];
  bit            sready_exp = 1'b0;
  bit            err_exp = 1'b0;

  function automatic bit [1:0] quant(int x);
    if (x < -256) return 2'd0;
    if (x < 0)    return 2'd1;
    if (x < 256)  return 2'd2;
    return 2'd3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  // Advance one clock, updating the model with this cycle's handshakes, then compare.
  task automatic step();
    bit acc, hs, errn;
    logic [DW-1:0] v;
    errn = 1'b0;
    if (rst_n) begin
      acc = s_valid && sready_exp;
      hs  = (outq.size() > 0) && m_ready;
      if (hs) begin
        $display("vec %0d out %h at cycle %0d", vcount, outq[0], cycle);
        vcount++;
        void'(outq.pop_front());
      end
      if (acc) begin
        cur.push_back(quant(int'($signed(s_data))));
        if (cur.size() == N) begin
          v = '0;
          foreach (cur[i]) v[2*i +: 2] = cur[i];
          outq.push_back(v);
          errn = !s_last;
          cur.delete();
        end else if (s_last) begin
          errn = 1'b1;
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_n) begin
      outq.delete();
      cur.delete();
      sready_exp = 1'b0;
      err_exp    = 1'b0;
    end else begin
      sready_exp = (outq.size() < 2);
      err_exp    = errn;
    end
    check("s_ready", s_ready, sready_exp);
    check("m_valid", m_valid, outq.size() > 0);
    check("err_len", err_len, err_exp);
    if (!rst_n) check("m_data_rst", m_data, 0);
    else if (outq.size() > 0) check("m_data", m_data, outq[0]);
  endtask

  task automatic send(input int x, input bit last);
    s_valid = 1'b1;
    s_data  = x[IN_W-1:0];
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic int rand_feature();
    int t;
    case ($urandom_range(0, 3))
      0: t = -256;
      1: t = 0;
      2: t = 256;
      default: return int'($signed(16'($urandom())));
    endcase
    return t + int'($urandom_range(0, 2)) - 1;
  endfunction

  int pulses;
  int last_pulse;

  initial begin
    // Power-on reset.
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Quantize boundaries.
    m_ready = 1'b1;
    send(-257, 0);
    send(-256, 0);
    send(0, 0);
    send(256, 1);
    check("t2_data", m_data, 8'he4);
    check("t2_valid", m_valid, 1);
    step();
    check("t2_valid_drop", m_valid, 0);

    // Backpressure: two vectors queue up, then drain.
    m_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(rand_feature(), (i % N) == N - 1);
    check("t3_sready_low", s_ready, 0);
    repeat (3) step();
    m_ready = 1'b1;
    step();
    check("t3_sready_back", s_ready, 1);
    step();

    // Throughput: continuous input, one pulse every N cycles.
    pulses = 0;
    last_pulse = -1;
    for (int i = 0; i < 10 * N; i++) begin
      send(rand_feature(), (i % N) == N - 1);
      s_valid = 1'b1;
      if (m_valid) begin
        if (last_pulse >= 0) check("t4_gap", cycle - last_pulse, N);
        last_pulse = cycle;
        pulses++;
      end
    end
    s_valid = 1'b0;
    check("t4_pulses", pulses, 10);
    step();

    // Short frame, then a clean full frame.
    send(300, 0);
    send(300, 1);
    check("t5_err", err_len, 1);
    check("t5_novalid", m_valid, 0);
    send(-1000, 0);
    send(-100, 0);
    send(100, 0);
    send(1000, 1);
    check("t5_data", m_data, 8'he4);
    step();

    // Missing s_last: vector emitted together with the error pulse.
    for (int i = 0; i < N; i++) send(rand_feature(), 0);
    check("t6_valid", m_valid, 1);
    check("t6_err", err_len, 1);
    step();

    // Random traffic with occasional framing errors.
    for (int i = 0; i < 600; i++) begin
      m_ready = ($urandom_range(0, 9) < 6);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = IN_W'(rand_feature());
      s_last  = (cur.size() == N - 1);
      if ($urandom_range(0, 19) == 0) s_last = !s_last;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    // Reset in the middle of a frame with a held vector.
    m_ready = 1'b0;
    for (int i = 0; i < N + 2; i++) send(rand_feature(), (i % N) == N - 1);
    rst_n = 1'b0;
    #1;
    check("t1_valid_async", m_valid, 0);
    check("t1_data_async", m_data, 0);
    check("t1_err_async", err_len, 0);
    outq.delete();
    cur.delete();
    sready_exp = 1'b0;
    s_valid = 1'b1;
    repeat (3) step();
    s_valid = 1'b0;
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    send(-300, 0);
    send(-10, 0);
    send(10, 0);
    send(300, 1);
    check("t1_first_vec", m_data, 8'he4);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
